// File: rtl/sll_iter_pkg.sv
// Shared ALU definitions: operand widths, iterative-shifter state encoding and
// the single conditional shift stage reused by iterative shifters.
package alu_pkg;

    localparam int XLEN    = 64;
    localparam int SHAMT_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sll_state_e;

    // Stage j moves the operand left by 2**j when enabled.
    function automatic logic [XLEN-1:0] sll_stage(
        input logic [XLEN-1:0] acc,
        input logic            en,
        input logic [2:0]      j
    );
        return en ? (acc << (7'd1 << j)) : acc;
    endfunction

endpackage

// File: rtl/sll_iter_if.sv
// Request/response bundle of the iterative left shifter.
// SLL_WORD_EN adds the 'word' request bit (RV64 SLLW).
interface sll_iter_if;
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   a;
    logic [SHAMT_W-1:0] shamt;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   y;
    logic              busy;
`ifdef SLL_WORD_EN
    logic              word;

    modport slave  (input  in_valid, a, shamt, word, out_ready,
                    output in_ready, out_valid, y, busy);
    modport master (output in_valid, a, shamt, word, out_ready,
                    input  in_ready, out_valid, y, busy);
`else
    modport slave  (input  in_valid, a, shamt, out_ready,
                    output in_ready, out_valid, y, busy);
    modport master (output in_valid, a, shamt, out_ready,
                    input  in_ready, out_valid, y, busy);
`endif

endinterface

// File: rtl/sll_iter_stage.sv
// Combinational slice applying STEP consecutive conditional shift stages
// starting at stage i_k.
module sll_iter_stage #(
    parameter int STEP = 1
) (
    input  logic [alu_pkg::XLEN-1:0]    i_acc,
    input  logic [alu_pkg::SHAMT_W-1:0] i_sh,
    input  logic [2:0]                  i_k,
    output logic [alu_pkg::XLEN-1:0]    o_acc
);
    import alu_pkg::*;

    logic [XLEN-1:0] w_acc;
    logic [2:0]      w_idx;

    always_comb begin
        w_acc = i_acc;
        w_idx = '0;
        for (int unsigned j = 0; j < STEP; j++) begin
            w_idx = i_k + 3'(j);
            w_acc = sll_stage(w_acc, (w_idx < 3'd6) ? i_sh[w_idx] : 1'b0, w_idx);
        end
        o_acc = w_acc;
    end

endmodule

// File: rtl/sll_iter.sv
// Iterative RV64 shift-left-logical: resolves STEP shift stages per clock,
// latency 6/STEP cycles. Define SLL_WORD_EN for the SLLW (32-bit, sign-extended) variant.
module sll_iter #(
    parameter int XLEN = 64,
    parameter int STEP = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    sll_iter_if.slave bus
);
    import alu_pkg::*;

    localparam logic [2:0] LAST_K = 3'(SHAMT_W - STEP);
    localparam logic [2:0] K_INC  = 3'(STEP);

    sll_state_e         r_state;
    sll_state_e         w_state_nxt;
    logic [XLEN-1:0]    r_acc;
    logic [SHAMT_W-1:0] r_sh;
    logic [2:0]         r_k;
    logic [XLEN-1:0]    r_y;
    logic [XLEN-1:0]    w_acc_nxt;
    logic               w_last;
`ifdef SLL_WORD_EN
    logic               r_word;
`endif

    sll_iter_stage #(.STEP(STEP)) u_stage (
        .i_acc (r_acc),
        .i_sh  (r_sh),
        .i_k   (r_k),
        .o_acc (w_acc_nxt)
    );

    assign w_last = (r_state == SHIFT) && (r_k == LAST_K);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_state_nxt = SHIFT;
            SHIFT:   if (w_last)        w_state_nxt = DONE;
            DONE:    if (bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_sh   <= '0;
            r_k    <= '0;
            r_y    <= '0;
`ifdef SLL_WORD_EN
            r_word <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_acc  <= bus.a;
                        r_k    <= '0;
`ifdef SLL_WORD_EN
                        // SLLW ignores shamt[5]: kill stage 5 at capture
                        r_sh   <= bus.word ? {1'b0, bus.shamt[4:0]} : bus.shamt;
                        r_word <= bus.word;
`else
                        r_sh   <= bus.shamt;
`endif
                    end
                end
                SHIFT: begin
                    r_acc <= w_acc_nxt;
                    r_k   <= r_k + K_INC;
                    if (w_last) begin
`ifdef SLL_WORD_EN
                        r_y <= r_word ? {{(XLEN-32){w_acc_nxt[31]}}, w_acc_nxt[31:0]}
                                      : w_acc_nxt;
`else
                        r_y <= w_acc_nxt;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.y         = r_y;

endmodule
